// File: rtl/bk_wide_add_seq_if.sv
// Operand and result valid/ready channels for the sequenced wide adder.
// Producer/consumer side is master; the sequencer is slave.
interface bk_wide_add_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub,
    output out_ready,
    input  in_ready,
    input  out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub,
    input  out_ready,
    output in_ready,
    output out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/bk_wide_add_seq.sv
// Wide add/sub built by stepping one external 8-bit adder slice
// per cycle, LS slice first, with the carry chained in a register.
module bk_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bk_wide_add_seq_if.slave   io,
  output logic [7:0]         add_a,
  output logic [7:0]         add_b,
  output logic               add_cin,
  input  logic [7:0]         add_sum,
  input  logic               add_cout,
  output logic               busy
);

  localparam int W  = 8 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           last;

  assign last = (idx_q == IW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.in_a;
          b_d     = io.in_sub ? ~io.in_b : io.in_b;
          carry_d = io.in_sub | io.in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[{idx_q, 3'b000} +: 8];
        add_b   = b_q[{idx_q, 3'b000} +: 8];
        add_cin = carry_q;
        sum_d[{idx_q, 3'b000} +: 8] = add_sum;
        carry_d = add_cout;
        if (last) begin
          cout_d  = add_cout;
          // b_q already holds ~B for subtract, so one rule covers both
          ovf_d   = (a_q[W-1] == b_q[W-1]) &
                    (add_sum[7] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_sum   = sum_q;
  assign io.out_cout  = cout_q;
  assign io.out_ovf   = ovf_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bk_wide_add_seq.sv
// Directed bench for bk_wide_add_seq with a stub 8-bit adder
// and a queue of expected results.
module tb_bk_wide_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bk_wide_add_seq_if #(.W(W)) bus ();

  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout, busy;

  assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

  bk_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [W:0]  r;
    longint      sa, sbv, res, lim;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    res = sub ? (sa - sbv) : (sa + sbv + longint'(cin));
    lim = longint'(1) << (W - 1);
    e.s = r[W-1:0];
    e.c = r[W];
    e.o = (res >= lim) || (res < -lim);
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_sbq"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"},  64'(bus.out_sum),  64'(e.s));
      chk({tag, "_cout"}, 64'(bus.out_cout), 64'(e.c));
      chk({tag, "_ovf"},  64'(bus.out_ovf),  64'(e.o));
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic cin,
                    input logic sub, input int hold);
    exp_t       e;
    logic [7:0] b0;
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    b0 = sub ? ~b[7:0] : b[7:0];
    chk({tag, "_s0a"}, 64'(add_a), 64'(a[7:0]));
    chk({tag, "_s0b"}, 64'(add_b), 64'(b0));
    chk({tag, "_s0c"}, 64'(add_cin), 64'(sub | cin));
    for (int k = 1; k <= WORDS; k++) begin
      @(posedge clk);
      #1 chk({tag, "_lat"}, 64'(bus.out_valid), 64'(k == WORDS));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.in_valid = h[0];
      bus.in_a     = 32'hDEAD0000 + 32'(h);
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      e = sb[0];
      chk({tag, "_hsum"}, 64'(bus.out_sum), 64'(e.s));
      chk({tag, "_hrdy"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "_hval"}, 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    check_out(tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  logic [W-1:0] ta [4];
  logic [W-1:0] tb_ [4];
  int nacc, nrcv, last;
  bit pend;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy",  64'(bus.in_ready),  64'd1);
    chk("rst_val",  64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy),          64'd0);
    chk("rst_sum",  64'(bus.out_sum),   64'd0);
    chk("rst_adda", 64'(add_a),         64'd0);
    rst_n = 1'b1;

    op("wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    op("sub57", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 0);
    op("povf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    op("novf",  32'h80000000, 32'h00000001, 1'b1, 1'b1, 0);
    op("cin",   32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 0);
    op("hold",  32'h0F0F0F0F, 32'h81010101, 1'b0, 1'b0, 10);

    @(negedge clk);
    bus.in_a     = 32'hAAAAAAAA;
    bus.in_b     = 32'h55555555;
    bus.in_sub   = 1'b0;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_val",  64'(bus.out_valid), 64'd0);
    chk("arst_rdy",  64'(bus.in_ready),  64'd1);
    chk("arst_busy", 64'(busy),          64'd0);
    chk("arst_adda", 64'(add_a),         64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_sum", 64'(bus.out_sum), 64'd0);
    op("post", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 0);

    ta[0] = 32'h00000010; tb_[0] = 32'h00000020;
    ta[1] = 32'hFFFF0000; tb_[1] = 32'h00010000;
    ta[2] = 32'h7FFF7FFF; tb_[2] = 32'h00010001;
    ta[3] = 32'hCAFEBABE; tb_[3] = 32'h01020304;
    nacc = 0;
    nrcv = 0;
    last = -1;
    pend = 1'b0;
    bus.in_a      = ta[0];
    bus.in_b      = tb_[0];
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && nrcv < 4; cyc++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (nacc < 4) begin
          bus.in_a = ta[nacc];
          bus.in_b = tb_[nacc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        check_out("tput");
        nrcv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (last >= 0) chk("tput_gap", 64'(cyc - last), 64'd6);
        last = cyc;
        sb.push_back(model(bus.in_a, bus.in_b, 1'b0, 1'b0));
        nacc++;
        pend = 1'b1;
      end
    end
    chk("tput_count", 64'(nrcv), 64'd4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
